// File: rtl/texto_pkg.sv
// Shared widths, character codes, preset pattern and FSM encoding for the
// text-overlay character buffer and its arbiter.
package texto_pkg;

  localparam int N_SLOTS = 8;
  localparam int AW      = 3;
  localparam int CW      = 2;

  localparam logic [CW-1:0] BLANCO  = 2'b00;
  localparam logic [CW-1:0] LETRA_D = 2'b01;
  localparam logic [CW-1:0] LETRA_J = 2'b10;

  // Slot 0 sits in the least significant bits.
  localparam logic [N_SLOTS*CW-1:0] PRESET =
    {{(N_SLOTS-3){BLANCO}}, LETRA_J, LETRA_D, LETRA_D};

  typedef enum logic {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } estado_t;

  function automatic logic [CW-1:0] preset_slot(input int idx);
    return PRESET[idx*CW +: CW];
  endfunction

endpackage

// File: rtl/buffer_caracteres.sv
// N_SLOTS x CW character register file: one write port, one registered read
// port, asynchronous reset reloads the preset pattern.
module buffer_caracteres
  import texto_pkg::*;
(
  input  logic          reloj,
  input  logic          resetM,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [CW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [CW-1:0] rdata
);

  logic [CW-1:0] mem [N_SLOTS];

  always_ff @(posedge reloj or posedge resetM) begin
    if (resetM) begin
      for (int i = 0; i < N_SLOTS; i++) mem[i] <= preset_slot(i);
      rdata <= BLANCO;
    end else begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/arbitro_buffer_texto.sv
// Text-overlay buffer arbiter: prefetches one tile ahead of the raster and
// shares the single buffer port between video, host writes and bulk clear.
module arbitro_buffer_texto
  import texto_pkg::*;
#(
  parameter logic [6:0] COL0 = 7'd43,
  parameter logic [5:0] ROW0 = 6'd16
) (
  input  logic          reloj,
  input  logic          resetM,
  input  logic          tick,
  input  logic [9:0]    Qh,
  input  logic [9:0]    Qv,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [CW-1:0] wr_data,
  output logic          wr_ack,
  input  logic          clr,
  output logic          busy,
  output logic [CW-1:0] caracter,
  output logic          en_texto,
  output logic [7:0]    cnt_conflictos
);

  // 8-bit column compare keeps tile 127+1 from wrapping back into range.
  localparam logic [7:0] COL_LO = {1'b0, COL0};
  localparam logic [7:0] COL_HI = COL_LO + 8'(N_SLOTS);

  estado_t       estado;
  logic [AW-1:0] cnt_clr;
  logic [7:0]    col_sig;
  logic          en_ventana, fetch_stb, tile_stb, video_rd, grant, defer;
  logic          buf_we;
  logic [AW-1:0] buf_waddr, slot_rd;
  logic [CW-1:0] buf_wdata, rd_data;
  logic          vld_p1, flag_p1, leido_p1, flag_p2;
  logic [CW-1:0] char_next;
  logic          qv_unused;

  assign qv_unused = &{1'b0, Qv[3:0]};

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    col_sig    = {1'b0, Qh[9:3]} + 8'd1;
    en_ventana = (col_sig >= COL_LO) && (col_sig < COL_HI) && (Qv[9:4] == ROW0);
    slot_rd    = AW'(col_sig - COL_LO);
    fetch_stb  = tick && (Qh[2:0] == 3'b101);
    tile_stb   = tick && (Qh[2:0] == 3'b111);
    video_rd   = fetch_stb && en_ventana && (estado == RUN);
    grant      = wr_req && (estado == RUN) && !wr_ack && !clr && !video_rd;
    defer      = wr_req && (estado == RUN) && !wr_ack && video_rd;
    buf_we     = 1'b0;
    buf_waddr  = wr_addr;
    buf_wdata  = wr_data;
    if (estado == CLEAR) begin
      buf_we    = 1'b1;
      buf_waddr = cnt_clr;
      buf_wdata = BLANCO;
    end else if (grant) begin
      buf_we    = 1'b1;
    end
  end

  buffer_caracteres u_buffer (
    .reloj  (reloj),
    .resetM (resetM),
    .we     (buf_we),
    .waddr  (buf_waddr),
    .wdata  (buf_wdata),
    .re     (video_rd),
    .raddr  (slot_rd),
    .rdata  (rd_data)
  );

  always_ff @(posedge reloj or posedge resetM) begin
    if (resetM) begin
      estado         <= RUN;
      cnt_clr        <= '0;
      busy           <= 1'b0;
      wr_ack         <= 1'b0;
      cnt_conflictos <= '0;
    end else begin
      wr_ack <= grant;
      if (defer) cnt_conflictos <= sat_inc(cnt_conflictos);
      case (estado)
        RUN: begin
          if (clr) begin
            estado  <= CLEAR;
            cnt_clr <= '0;
            busy    <= 1'b1;
          end
        end
        CLEAR: begin
          if (clr) begin
            cnt_clr <= '0;
          end else if (cnt_clr == AW'(N_SLOTS-1)) begin
            estado <= RUN;
            busy   <= 1'b0;
          end else begin
            cnt_clr <= cnt_clr + 1'b1;
          end
        end
        default: estado <= RUN;
      endcase
    end
  end

  always_ff @(posedge reloj or posedge resetM) begin
    if (resetM) begin
      vld_p1    <= 1'b0;
      flag_p1   <= 1'b0;
      leido_p1  <= 1'b0;
      flag_p2   <= 1'b0;
      char_next <= BLANCO;
      caracter  <= BLANCO;
      en_texto  <= 1'b0;
    end else begin
      // p1: fetch issued, buffer read in flight
      vld_p1 <= fetch_stb;
      if (fetch_stb) begin
        flag_p1  <= en_ventana;
        leido_p1 <= video_rd;
      end
      // p2: read data captured as the next tile's code
      if (vld_p1) begin
        flag_p2   <= flag_p1;
        char_next <= leido_p1 ? rd_data : BLANCO;
      end
      // tile boundary: present the prefetched code
      if (tile_stb) begin
        caracter <= flag_p2 ? char_next : BLANCO;
        en_texto <= flag_p2;
      end
    end
  end

endmodule

// File: tb/tb_arbitro_buffer_texto.sv
// Self-checking bench for arbitro_buffer_texto: directed raster passes checked
// against expectation tables, then randomized traffic against a reference model.
module tb_arbitro_buffer_texto;
  import texto_pkg::*;

  logic          reloj = 1'b0;
  logic          resetM, tick, clr, wr_req;
  logic [9:0]    Qh, Qv;
  logic [AW-1:0] wr_addr;
  logic [CW-1:0] wr_data;
  logic          wr_ack, busy, en_texto;
  logic [CW-1:0] caracter;
  logic [7:0]    cnt_conflictos;

  int errores = 0;
  int checks  = 0;

  arbitro_buffer_texto dut (
    .reloj          (reloj),
    .resetM         (resetM),
    .tick           (tick),
    .Qh             (Qh),
    .Qv             (Qv),
    .wr_req         (wr_req),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_ack         (wr_ack),
    .clr            (clr),
    .busy           (busy),
    .caracter       (caracter),
    .en_texto       (en_texto),
    .cnt_conflictos (cnt_conflictos)
  );

  always #5 reloj = ~reloj;

  // Reference model state
  int m_mem [8];
  int m_clr_idx;
  int m_ack, m_cnt, m_car, m_en, m_code, m_flag;

  typedef struct {
    int tile;
    int car;
    int en;
  } vec_t;
  vec_t tab [10];
  int obs3 [64];
  int obs6 [64];
  int obsen [64];

  task automatic model_reset();
    m_mem = '{1, 1, 2, 0, 0, 0, 0, 0};
    m_clr_idx = -1;
    m_ack = 0; m_cnt = 0; m_car = 0; m_en = 0; m_code = 0; m_flag = 0;
  endtask

  task automatic model_step();
    int  c, slot;
    bit  win, fetch, clearing, rd, grant, defer;
    c        = int'(Qh[9:3]) + 1;
    win      = (c >= 43) && (c < 51) && (int'(Qv[9:4]) == 16);
    slot     = c - 43;
    fetch    = tick && (Qh[2:0] == 3'd5);
    clearing = (m_clr_idx >= 0);
    rd       = fetch && win && !clearing;
    grant    = wr_req && !clearing && !rd && (m_ack == 0) && !clr;
    defer    = wr_req && !clearing && (m_ack == 0) && rd;
    if (fetch) begin
      m_code = rd ? m_mem[slot] : 0;
      m_flag = win ? 1 : 0;
    end
    if (tick && (Qh[2:0] == 3'd7)) begin
      m_car = (m_flag != 0) ? m_code : 0;
      m_en  = m_flag;
    end
    if (clearing) begin
      m_mem[m_clr_idx] = 0;
      if (clr) m_clr_idx = 0;
      else if (m_clr_idx == 7) m_clr_idx = -1;
      else m_clr_idx++;
    end else if (clr) begin
      m_clr_idx = 0;
    end
    if (grant) m_mem[int'(wr_addr)] = int'(wr_data);
    m_ack = grant ? 1 : 0;
    if (defer && m_cnt < 255) m_cnt++;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errores++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("caracter", int'(caracter), m_car);
    chk("en_texto", int'(en_texto), m_en);
    chk("wr_ack", int'(wr_ack), m_ack);
    chk("busy", int'(busy), (m_clr_idx >= 0) ? 1 : 0);
    chk("cnt_conflictos", int'(cnt_conflictos), m_cnt);
  endtask

  task automatic step();
    @(posedge reloj);
    model_step();
    @(negedge reloj);
    check_model();
  endtask

  task automatic row_pass(input int row, input int inj_q, input int inj_addr,
                          input int inj_data, input bit hold_req);
    for (int q = 320; q <= 423; q++) begin
      Qh   = 10'(q);
      Qv   = 10'(row * 16 + 3);
      tick = 1'b1;
      if (q == inj_q) begin
        wr_req  = 1'b1;
        wr_addr = AW'(inj_addr);
        wr_data = CW'(inj_data);
      end
      if (hold_req) wr_req = 1'b1;
      step();
      if (q == inj_q) chk("ack_diferido", int'(wr_ack), 0);
      if (inj_q >= 0 && q == inj_q + 1) chk("ack_tardio", int'(wr_ack), 1);
      if (m_ack != 0 && !hold_req) wr_req = 1'b0;
      if (q % 8 == 3) begin
        obs3[q/8]  = int'(caracter);
        obsen[q/8] = int'(en_texto);
      end
      if (q % 8 == 6) obs6[q/8] = int'(caracter);
    end
    tick = 1'b0;
    Qh   = '0;
    Qv   = '0;
  endtask

  task automatic compare_table(input string tag, input bit fuera);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("%s_t%0d_car", tag, tab[i].tile), obs3[tab[i].tile], fuera ? 0 : tab[i].car);
      chk($sformatf("%s_t%0d_pre", tag, tab[i].tile), obs6[tab[i].tile], fuera ? 0 : tab[i].car);
      chk($sformatf("%s_t%0d_en", tag, tab[i].tile), obsen[tab[i].tile], fuera ? 0 : tab[i].en);
    end
  endtask

  initial begin
    int nb, ack_busy, acks, cnt_antes, qh_r, row_r, qv_lo;

    for (int i = 0; i < 10; i++) begin
      tab[i].tile = 42 + i;
      tab[i].car  = 0;
      tab[i].en   = (i >= 1 && i <= 8) ? 1 : 0;
    end
    tab[1].car = 1;
    tab[2].car = 1;
    tab[3].car = 2;

    resetM = 1'b1; tick = 1'b0; clr = 1'b0; wr_req = 1'b0;
    Qh = '0; Qv = '0; wr_addr = '0; wr_data = '0;
    model_reset();
    repeat (2) @(negedge reloj);
    resetM = 1'b0;
    chk("rst_caracter", int'(caracter), 0);
    chk("rst_en_texto", int'(en_texto), 0);
    chk("rst_wr_ack", int'(wr_ack), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cnt", int'(cnt_conflictos), 0);
    step();

    // Preset pattern on row 16
    row_pass(16, -1, 0, 0, 1'b0);
    compare_table("preset", 1'b0);

    // Host write slot3 = J on an idle raster
    wr_req = 1'b1; wr_addr = 3'd3; wr_data = 2'b10;
    step();
    chk("ack_host", int'(wr_ack), 1);
    wr_req = 1'b0;
    step();
    chk("ack_pulso", int'(wr_ack), 0);
    row_pass(16, -1, 0, 0, 1'b0);
    tab[4].car = 2;
    compare_table("host", 1'b0);

    // Request collides with the fetch of slot 1
    row_pass(16, 43*8 + 5, 1, 0, 1'b0);
    compare_table("conflicto", 1'b0);
    chk("cnt_conflicto", int'(cnt_conflictos), 1);
    row_pass(16, -1, 0, 0, 1'b0);
    tab[2].car = 0;
    compare_table("tras_conflicto", 1'b0);

    // Bulk clear with a write requested mid-clear
    clr = 1'b1;
    step();
    clr = 1'b0;
    nb = int'(busy); ack_busy = 0; acks = 0;
    for (int k = 0; k < 20; k++) begin
      if (k == 3) begin
        wr_req = 1'b1; wr_addr = 3'd5; wr_data = 2'b01;
      end
      step();
      if (busy) nb++;
      if (wr_ack && busy) ack_busy++;
      if (wr_ack) acks++;
      if (m_ack != 0) wr_req = 1'b0;
    end
    chk("busy_ciclos", nb, 8);
    chk("ack_en_clear", ack_busy, 0);
    chk("ack_tras_clear", acks, 1);
    for (int i = 0; i < 10; i++) tab[i].car = 0;
    tab[6].car = 1;
    row_pass(16, -1, 0, 0, 1'b0);
    compare_table("clear", 1'b0);

    // Rows outside the window with continuous host traffic
    cnt_antes = int'(cnt_conflictos);
    wr_addr = 3'd7; wr_data = 2'b11;
    row_pass(15, -1, 0, 0, 1'b1);
    compare_table("fila15", 1'b1);
    row_pass(17, -1, 0, 0, 1'b1);
    compare_table("fila17", 1'b1);
    chk("cnt_fuera", int'(cnt_conflictos), cnt_antes);
    wr_req = 1'b0;
    step();
    step();

    // Reset in the middle of a clear with a request pending
    clr = 1'b1;
    step();
    clr = 1'b0;
    step();
    wr_req = 1'b1; wr_addr = 3'd2; wr_data = 2'b11;
    step();
    resetM = 1'b1;
    #1;
    chk("rst2_busy", int'(busy), 0);
    chk("rst2_wr_ack", int'(wr_ack), 0);
    chk("rst2_caracter", int'(caracter), 0);
    chk("rst2_en_texto", int'(en_texto), 0);
    chk("rst2_cnt", int'(cnt_conflictos), 0);
    model_reset();
    wr_req = 1'b0;
    @(negedge reloj);
    resetM = 1'b0;
    acks = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (wr_ack) acks++;
    end
    chk("ack_abortado", acks, 0);
    tab[1].car = 1; tab[2].car = 1; tab[3].car = 2;
    for (int i = 4; i < 10; i++) tab[i].car = 0;
    row_pass(16, -1, 0, 0, 1'b0);
    compare_table("preset2", 1'b0);

    // Randomized traffic against the model
    qh_r = 300; row_r = 16; qv_lo = 0;
    for (int n = 0; n < 3000; n++) begin
      Qh   = 10'(qh_r);
      Qv   = 10'(row_r * 16 + qv_lo);
      tick = ($urandom_range(0, 3) != 0);
      clr  = ($urandom_range(0, 150) == 0);
      if (!wr_req && $urandom_range(0, 2) == 0) begin
        wr_req  = 1'b1;
        wr_addr = AW'($urandom_range(0, 7));
        wr_data = CW'($urandom_range(0, 3));
      end
      step();
      if (m_ack != 0) wr_req = 1'b0;
      if (tick) begin
        if (qh_r == 440) begin
          qh_r  = 300;
          row_r = int'($urandom_range(15, 17));
          qv_lo = int'($urandom_range(0, 15));
        end else begin
          qh_r++;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errores, checks);
    $finish;
  end

endmodule

// File: doc/arbitro_buffer_texto.md
Name: arbitro_buffer_texto

Overview:
- Owns the small character buffer behind the text overlay and schedules all access to it.
- Prefetches the 2-bit character code for each 8-pixel tile one tile ahead of the raster, and presents it to the glyph ROM / pixel-select datapath as a stable per-tile code.
- Shares the buffer's single port between the video fetcher (highest priority), a host write port (req/ack) and a bulk-clear sequencer.

Parameters:
- N_SLOTS, 8, number of character slots (columns) in the overlay window.
- AW, 3, slot address width (clog2(N_SLOTS)).
- CW, 2, character code width; 00 = blank, 01 = D, 10 = J, 11 = reserved.
- COL0, 7'd43, first tile column (Qh[9:3]) of the window.
- ROW0, 6'd16, tile row (Qv[9:4]) of the window.

Ports:
- reloj  in  1  system clock; all state on rising edge.
- resetM  in  1  asynchronous, active-high reset.
- tick  in  1  pixel strobe; Qh/Qv advance only on cycles where tick=1.
- Qh  in  10  horizontal pixel counter.
- Qv  in  10  vertical pixel counter.
- wr_req  in  1  host write request; held until wr_ack.
- wr_addr  in  AW  host slot address.
- wr_data  in  CW  host character code.
- wr_ack  out  1  one-cycle pulse: write performed.
- clr  in  1  single-cycle pulse: clear all slots to 00.
- busy  out  1  high while clear is in progress.
- caracter  out  CW  code for the current tile; 0 outside the window.
- en_texto  out  1  current tile lies inside the window.
- cnt_conflictos  out  8  saturating count of cycles in which a host write was deferred by a video fetch.

Behaviour:
- Reset (async): caracter=0, en_texto=0, wr_ack=0, busy=0, cnt_conflictos=0, FSM=RUN.
  - Buffer preset: slot0=01, slot1=01, slot2=10, all other slots 00.
- Window membership:
  - Tile column c is in the window when COL0 <= c < COL0+N_SLOTS and Qv[9:4]==ROW0.
  - Slot index = c-COL0, truncated to AW bits.
  - Compare c using 8-bit arithmetic so that 127+1 does not wrap into the window.
- Video fetch:
  - Issued in the cycle where tick=1 and Qh[2:0]==3'b101, for c = Qh[9:3]+1.
  - A fetch is issued only if c is in the window; the in-window flag is registered alongside the fetch.
  - Read latency is 1 cycle; the result is latched into char_next.
- Tile update: on the cycle where tick=1 and Qh[2:0]==3'b111, caracter <= (flag ? char_next : 0) and en_texto <= flag.
  - Latency from the fetch strobe to the output is 2 cycles, which is valid when tick is high every cycle.
- Arbitration, one buffer access per cycle, in this priority order:
  - clear write (in CLEAR state);
  - video read;
  - host write.
- Host handshake:
  - A write is granted in any cycle with wr_req=1, no higher-priority access, FSM=RUN, and wr_ack currently 0.
  - wr_ack=1 in the following cycle, for exactly one cycle.
  - Maximum host throughput is 1 write per 2 cycles.
- Deferred host writes:
  - A write deferred by a video read increments cnt_conflictos, saturating at 255.
  - The deferred write completes in the next free cycle, so the worst-case wait while RUN is 1 cycle.
- Same-slot read/write in one cycle: the read wins and returns the old data; the write lands next cycle.
- FSM RUN -> CLEAR when clr=1.
  - In CLEAR: busy=1; counter 0..N_SLOTS-1 writes 00 to one slot per cycle.
  - After slot N_SLOTS-1: return to RUN, busy=0. CLEAR takes N_SLOTS cycles.
  - clr asserted during CLEAR restarts the counter at 0.
  - Video fetches during CLEAR return 00; the buffer is not read.
  - Host writes are never granted in CLEAR. wr_req stays pending and completes after RUN resumes, so a write pending across a clear survives it.
- clr and a host grant would coincide in the same cycle: clr wins and the write is not performed.
- Reset mid-clear or mid-handshake: all state returns to reset values and the preset pattern is restored; no wr_ack is issued for the aborted request.

Decomposition:
- Package texto_pkg:
  - CW, AW, N_SLOTS;
  - character code constants BLANCO=00, LETRA_D=01, LETRA_J=10;
  - preset pattern;
  - FSM state encoding RUN/CLEAR.
- Sub-module buffer_caracteres: N_SLOTS x CW register file, 1 write port, 1 registered read port, async reset to the preset pattern.

Test Plan:
- Reset, then raster row 16 with tick=1 continuous -> caracter = 01, 01, 10, 00, 00, 00, 00, 00 for tiles 43..50; 0 with en_texto=0 at tiles 42 and 51; change occurs at Qh[2:0]=111 of the preceding tile.
- Host write slot3=10, idle raster -> wr_ack one cycle after the request; tile 46 later shows 10.
- wr_req rising in the same cycle as a fetch of slot1 (wr_addr=1, wr_data=00) -> fetch returns 01; wr_ack delayed 1 cycle; cnt_conflictos=1; the next frame shows 00 at tile 44.
- clr pulse -> busy high exactly 8 cycles; all tiles 00 afterwards. wr_req issued mid-clear -> wr_ack only after busy falls; data retained.
- Raster on row 15 and row 17 -> en_texto=0 and caracter=0 for all tiles; no fetches, so cnt_conflictos does not change under continuous wr_req.
- Assert resetM during CLEAR with wr_req pending -> outputs 0 immediately; preset pattern visible on the next row-16 pass.
